// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/status bundle between the multi-cycle RV32I controller (master)
// and the datapath it sequences (slave).
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       reg_write;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, instr_done, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, alu_control, reg_write, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM for the shared-memory processor.
// Optional cycle/instret counters are enabled with `define CTRL_PERF_CNT_EN.
module multicycle_ctrl_fsm (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_ctrl_fsm_if.master bus
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           cycle_cnt,
  output logic [31:0]           instret_cnt
`endif
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_q, state_d;

  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write;
  logic       instr_done, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, aluop, imm_src;
  logic [2:0] alu_control;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      // Only lw and sw reach MEMADR; op[5] tells them apart.
      S_MEMADR:  state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    aluop      = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      // Precompute the branch target from OldPC + imm while decoding.
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        aluop     = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = 2'b10;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = 2'b10;
        aluop      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      default: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Everything is gated by rst so a mid-instruction reset kills writes at once.
  assign bus.pc_write    = ~rst & (pc_update | (branch & bus.zero));
  assign bus.adr_src     = ~rst & adr_src;
  assign bus.mem_write   = ~rst & mem_write;
  assign bus.ir_write    = ~rst & ir_write;
  assign bus.reg_write   = ~rst & reg_write;
  assign bus.instr_done  = ~rst & instr_done;
  assign bus.illegal     = ~rst & illegal;
  assign bus.result_src  = rst ? 2'b00 : result_src;
  assign bus.alu_src_a   = rst ? 2'b00 : alu_src_a;
  assign bus.alu_src_b   = rst ? 2'b00 : alu_src_b;
  assign bus.imm_src     = rst ? 2'b00 : imm_src;
  assign bus.alu_control = rst ? 3'b000 : alu_control;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (instr_done) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-instruction phase plans
// built from the instruction-class rules, driven with random fields and zero.
module tb_multicycle_ctrl_fsm;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  multicycle_ctrl_fsm_if bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
  multicycle_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus),
                           .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt));
`else
  multicycle_ctrl_fsm dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AW, P_J, P_B, P_T} phase_t;
  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

  phase_t plan[$];

  function automatic logic [6:0] op_of(int k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_JAL:   return 7'b1101111;
      K_BEQ:   return 7'b1100011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic void fill_plan(int k);
    plan = {};
    plan.push_back(P_F);
    plan.push_back(P_D);
    case (k)
      K_LW:  begin plan.push_back(P_MA); plan.push_back(P_MR); plan.push_back(P_MWB); end
      K_SW:  begin plan.push_back(P_MA); plan.push_back(P_MW); end
      K_R:   begin plan.push_back(P_ER); plan.push_back(P_AW); end
      K_I:   begin plan.push_back(P_EI); plan.push_back(P_AW); end
      K_JAL: begin plan.push_back(P_J);  plan.push_back(P_AW); end
      K_BEQ: plan.push_back(P_B);
      default: for (int i = 0; i < 10; i++) plan.push_back(P_T);
    endcase
  endfunction

  // Arithmetic op implied by an R/I instruction's fields.
  function automatic logic [2:0] alu_of(int k, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (k == K_R && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [17:0] expv(phase_t p, int k, logic [2:0] f3, logic f7, logic z);
    logic pcw, adr, mw, irw, rw, done, ill;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; done = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; alu = 3'b000;
    imm = (k == K_SW) ? 2'b01 : (k == K_BEQ) ? 2'b10 : (k == K_JAL) ? 2'b11 : 2'b00;
    case (p)
      P_F:   begin irw = 1; sb = 2; rs = 2; pcw = 1; end
      P_D:   begin sa = 1; sb = 1; end
      P_MA:  begin sa = 2; sb = 1; end
      P_MR:  adr = 1;
      P_MWB: begin rs = 1; rw = 1; done = 1; end
      P_MW:  begin adr = 1; mw = 1; done = 1; end
      P_ER:  begin sa = 2; alu = alu_of(k, f3, f7); end
      P_EI:  begin sa = 2; sb = 1; alu = alu_of(k, f3, f7); end
      P_AW:  begin rw = 1; done = 1; end
      P_J:   begin sa = 1; sb = 2; pcw = 1; end
      P_B:   begin sa = 2; alu = 3'b001; pcw = z; done = 1; end
      default: ill = 1;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, imm, alu, rw, done, ill};
  endfunction

  function automatic logic [17:0] obs();
    return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.result_src,
            bus.alu_src_a, bus.alu_src_b, bus.imm_src, bus.alu_control,
            bus.reg_write, bus.instr_done, bus.illegal};
  endfunction

  // Runs up to maxc cycles of one instruction; entered and left just after a rising edge.
  task automatic exec_instr(input int k, input logic [2:0] f3, input logic f7,
                            input int zmode, input int maxc);
    logic        z;
    logic [17:0] got, exp;
    fill_plan(k);
    bus.op       = op_of(k);
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    for (int i = 0; i < plan.size() && i < maxc; i++) begin
      z = (zmode < 0) ? 1'($urandom_range(0, 1)) : zmode[0];
      bus.zero = z;
      #1;
      got = obs();
      exp = expv(plan[i], k, f3, f7, z);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL instr k=%0d cycle %0d phase %0d: got %h expected %h",
                 k, i, plan[i], got, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus.zero = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (obs() !== 18'h0 || dut.state_q !== 4'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: got outputs %h state %0d expected 0/0",
                 i, obs(), dut.state_q);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exec_instr(K_R, 3'b000, 1'b0, -1, 99);
  endtask

  task automatic test_lw();
    exec_instr(K_LW, 3'($urandom), 1'($urandom), -1, 99);
  endtask

  task automatic test_alu_decode();
    exec_instr(K_R, 3'b000, 1'b1, -1, 99);
    exec_instr(K_I, 3'b000, 1'b1, -1, 99);
    exec_instr(K_R, 3'b010, 1'b0, -1, 99);
    exec_instr(K_R, 3'b110, 1'b1, -1, 99);
    exec_instr(K_I, 3'b111, 1'b0, -1, 99);
    exec_instr(K_R, 3'b001, 1'b1, -1, 99);
  endtask

  task automatic test_beq();
    exec_instr(K_BEQ, 3'b000, 1'b0, 1, 99);
    exec_instr(K_BEQ, 3'b000, 1'b0, 0, 99);
    exec_instr(K_SW, 3'b010, 1'b0, -1, 99);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++)
      exec_instr($urandom_range(0, 5), 3'($urandom), 1'($urandom), -1, 99);
  endtask

  task automatic test_reset_abort();
    exec_instr(K_SW, 3'b010, 1'b0, -1, 3);
    rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 18'h0 || dut.state_q !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got outputs %h state %0d expected 0/0", obs(), dut.state_q);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exec_instr(K_LW, 3'b010, 1'b0, -1, 99);
  endtask

  task automatic test_illegal();
    exec_instr(K_ILL, 3'($urandom), 1'($urandom), -1, 99);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.illegal !== 1'b0) begin
      errors++;
      $display("[TB] FAIL illegal_clear: got %b expected 0", bus.illegal);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exec_instr(K_JAL, 3'b000, 1'b0, -1, 99);
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    #1;
    checks++;
    if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
      errors++;
      $display("[TB] FAIL perf_reset: got cycle %0d instret %0d expected 0/0", cycle_cnt, instret_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exec_instr(K_SW, 3'b010, 1'b0, -1, 99);
    exec_instr(K_JAL, 3'b000, 1'b0, -1, 99);
    exec_instr(K_LW, 3'b010, 1'b0, -1, 99);
    checks++;
    if (instret_cnt !== 32'd3 || cycle_cnt !== 32'd13) begin
      errors++;
      $display("[TB] FAIL perf_count: got cycle %0d instret %0d expected 13/3", cycle_cnt, instret_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_alu_decode();
    test_beq();
    test_random();
    test_reset_abort();
    test_illegal();
`ifdef CTRL_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
